// File: rtl/tree_mux_pipe.sv
// tree_mux_pipe: one-hot mux of CNT WIDTH-bit inputs built as a tree of
// GROUP_SIZE-input AND-OR nodes, one register stage per tree level, with a
// valid/ready handshake, per-stage stall, bubble collapse and a binary index
// of the winning input.
// Optional macro TREE_MUX_PIPE_ERR_EN: adds multi-hot detection on err_multi;
// without it err_multi is tied low and no popcount logic exists.

module tree_mux_node #(
  parameter int WIDTH      = 32,
  parameter int GROUP_SIZE = 16,
  parameter int IDX_W      = 8,
  parameter int SCALE      = 1
) (
  input  logic [GROUP_SIZE-1:0][WIDTH-1:0] data_in,
  input  logic [GROUP_SIZE-1:0]            sel_in,
  input  logic [GROUP_SIZE-1:0][IDX_W-1:0] idx_in,
`ifdef TREE_MUX_PIPE_ERR_EN
  input  logic [GROUP_SIZE-1:0]            multi_in,
  output logic                             multi,
`endif
  output logic [WIDTH-1:0]                 data,
  output logic                             hit,
  output logic [IDX_W-1:0]                 idx
);

  int               loc;
  logic [IDX_W-1:0] sub;

  // AND-OR mux plus lowest-set priority encode; scanning downward lets the
  // lowest set position win. Child index rides along from the chosen child.
  always_comb begin
    data = '0;
    loc  = 0;
    sub  = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      data = data | (data_in[i] & {WIDTH{sel_in[i]}});
      if (sel_in[i]) begin
        loc = i;
        sub = idx_in[i];
      end
    end
    hit = |sel_in;
    idx = IDX_W'(loc * SCALE) + sub;
  end

`ifdef TREE_MUX_PIPE_ERR_EN
  logic seen, two;

  // More than one select set here, or any child already saw multi-hot.
  always_comb begin
    seen = 1'b0;
    two  = 1'b0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (sel_in[i]) begin
        if (seen) two = 1'b1;
        seen = 1'b1;
      end
    end
    multi = two | (|multi_in);
  end
`endif

endmodule

module tree_mux_pipe #(
  parameter int WIDTH      = 32,
  parameter int CNT        = 200,
  parameter int GROUP_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [WIDTH*CNT-1:0]    din,
  input  logic [CNT-1:0]          sel,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [WIDTH-1:0]        dout,
  output logic [((CNT > 2) ? $clog2(CNT) : 1)-1:0] dout_idx,
  output logic                    dout_hit,
  output logic                    err_multi
);

  function automatic int calc_levels();
    longint p = 1;
    int     r = 0;
    for (int l = 1; l <= 4; l++) begin
      p = p * GROUP_SIZE;
      if (r == 0 && p >= CNT) r = l;
    end
    return r;
  endfunction

  // Node count at tree level k (level 0 = the raw inputs).
  function automatic int n_at(input int k);
    int n = CNT;
    for (int i = 0; i < k; i++) n = (n + GROUP_SIZE - 1) / GROUP_SIZE;
    return n;
  endfunction

  function automatic int pow_g(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * GROUP_SIZE;
    return p;
  endfunction

  localparam int LEVELS = calc_levels();
  localparam int IDX_W  = (CNT > 2) ? $clog2(CNT) : 1;
  localparam int NMAX   = n_at(1);

  if (LEVELS < 1 || GROUP_SIZE < 2 || (GROUP_SIZE & (GROUP_SIZE - 1)) != 0) begin : g_bad_cfg
    $error("tree_mux_pipe: GROUP_SIZE must be a power of two and GROUP_SIZE**4 >= CNT");
  end

  logic [NMAX-1:0][WIDTH-1:0] q_data [1:LEVELS];
  logic [NMAX-1:0]            q_hit  [1:LEVELS];
  logic [NMAX-1:0][IDX_W-1:0] q_idx  [1:LEVELS];
`ifdef TREE_MUX_PIPE_ERR_EN
  logic [NMAX-1:0]            q_multi [1:LEVELS];
`endif
  logic [LEVELS:1]            vld_pipe;
  logic [LEVELS:1]            ld;

  // Stage k may load if it or any stage downstream of it has room, or the
  // consumer is taking the output this cycle.
  always_comb begin
    ld = '0;
    for (int k = 1; k <= LEVELS; k++) begin
      ld[k] = out_rdy;
      for (int j = k; j <= LEVELS; j++)
        if (!vld_pipe[j]) ld[k] = 1'b1;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NI = n_at(k - 1);
    localparam int NO = n_at(k);

    logic                                 v_prev;
    logic [NO*GROUP_SIZE-1:0][WIDTH-1:0]  c_data;
    logic [NO*GROUP_SIZE-1:0]             c_sel;
    logic [NO*GROUP_SIZE-1:0][IDX_W-1:0]  c_idx;
    logic [NMAX-1:0][WIDTH-1:0]           n_data;
    logic [NMAX-1:0]                      n_hit;
    logic [NMAX-1:0][IDX_W-1:0]           n_idx;
`ifdef TREE_MUX_PIPE_ERR_EN
    logic [NO*GROUP_SIZE-1:0]             c_multi;
    logic [NMAX-1:0]                      n_multi;
`endif

    if (k == 1) begin : g_v_first
      assign v_prev = in_vld;
    end else begin : g_v_next
      assign v_prev = vld_pipe[k-1];
    end

    // Child slots past the last real input of this level are tied to zero.
    for (genvar c = 0; c < NO*GROUP_SIZE; c++) begin : g_in
      if (c >= NI) begin : g_pad
        assign c_data[c] = '0;
        assign c_sel[c]  = 1'b0;
        assign c_idx[c]  = '0;
`ifdef TREE_MUX_PIPE_ERR_EN
        assign c_multi[c] = 1'b0;
`endif
      end else if (k == 1) begin : g_raw
        assign c_data[c] = din[c*WIDTH +: WIDTH];
        assign c_sel[c]  = sel[c];
        assign c_idx[c]  = '0;
`ifdef TREE_MUX_PIPE_ERR_EN
        assign c_multi[c] = 1'b0;
`endif
      end else begin : g_prev
        assign c_data[c] = q_data[k-1][c];
        assign c_sel[c]  = q_hit[k-1][c];
        assign c_idx[c]  = q_idx[k-1][c];
`ifdef TREE_MUX_PIPE_ERR_EN
        assign c_multi[c] = q_multi[k-1][c];
`endif
      end
    end

    for (genvar j = 0; j < NMAX; j++) begin : g_node
      if (j < NO) begin : g_real
        tree_mux_node #(
          .WIDTH     (WIDTH),
          .GROUP_SIZE(GROUP_SIZE),
          .IDX_W     (IDX_W),
          .SCALE     (pow_g(k - 1))
        ) u_node (
          .data_in (c_data[j*GROUP_SIZE +: GROUP_SIZE]),
          .sel_in  (c_sel[j*GROUP_SIZE +: GROUP_SIZE]),
          .idx_in  (c_idx[j*GROUP_SIZE +: GROUP_SIZE]),
`ifdef TREE_MUX_PIPE_ERR_EN
          .multi_in(c_multi[j*GROUP_SIZE +: GROUP_SIZE]),
          .multi   (n_multi[j]),
`endif
          .data    (n_data[j]),
          .hit     (n_hit[j]),
          .idx     (n_idx[j])
        );
      end else begin : g_none
        assign n_data[j] = '0;
        assign n_hit[j]  = 1'b0;
        assign n_idx[j]  = '0;
`ifdef TREE_MUX_PIPE_ERR_EN
        assign n_multi[j] = 1'b0;
`endif
      end
    end

    // Stage register: valid follows upstream whenever the stage may load;
    // payload only moves with a real beat so bubbles never disturb it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe[k] <= 1'b0;
        q_data[k]   <= '0;
        q_hit[k]    <= '0;
        q_idx[k]    <= '0;
`ifdef TREE_MUX_PIPE_ERR_EN
        q_multi[k]  <= '0;
`endif
      end else begin
        if (ld[k]) vld_pipe[k] <= v_prev;
        if (ld[k] && v_prev) begin
          q_data[k]  <= n_data;
          q_hit[k]   <= n_hit;
          q_idx[k]   <= n_idx;
`ifdef TREE_MUX_PIPE_ERR_EN
          q_multi[k] <= n_multi;
`endif
        end
      end
    end
  end

  assign in_rdy   = ld[1];
  assign out_vld  = vld_pipe[LEVELS];
  assign dout     = q_data[LEVELS][0];
  assign dout_idx = q_idx[LEVELS][0];
  assign dout_hit = q_hit[LEVELS][0];
`ifdef TREE_MUX_PIPE_ERR_EN
  assign err_multi = q_multi[LEVELS][0];
`else
  assign err_multi = 1'b0;
`endif

endmodule

// File: tb/tb_tree_mux_pipe.sv
// Directed bench for tree_mux_pipe at default parameters (CNT=200,
// GROUP_SIZE=16, two levels). Expected values are hand-derived constants.

module tb_tree_mux_pipe;

  localparam int W  = 32;
  localparam int N  = 200;
  localparam int IW = 8;
`ifdef TREE_MUX_PIPE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           in_vld;
  logic           in_rdy;
  logic [W*N-1:0] din;
  logic [N-1:0]   sel;
  logic           out_vld;
  logic           out_rdy;
  logic [W-1:0]   dout;
  logic [IW-1:0]  dout_idx;
  logic           dout_hit;
  logic           err_multi;

  int n_chk  = 0;
  int n_fail = 0;

  tree_mux_pipe #(.WIDTH(W), .CNT(N), .GROUP_SIZE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .din      (din),
    .sel      (sel),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .dout     (dout),
    .dout_idx (dout_idx),
    .dout_hit (dout_hit),
    .err_multi(err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic one_hot(input int b);
    sel    = '0;
    sel[b] = 1'b1;
  endtask

  int beats2 [3] = '{15, 16, 199};
  int beats3 [4] = '{5, 6, 7, 8};
  int got [$];
  int acc;
  int hi_cnt;
  logic a_in, a_out;

  initial begin
    rst = 1'b1; in_vld = 1'b0; sel = '0; din = '0; out_rdy = 1'b1;
    step(); step();

    // reset state
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_idx", 64'(dout_idx), 64'd0);
    chk("rst_hit", 64'(dout_hit), 64'd0);
    chk("rst_err", 64'(err_multi), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    rst = 1'b0;
    step();

    // 1: single beat, two-cycle latency
    din[0 +: W] = 32'hDEADBEEF;
    one_hot(0); in_vld = 1'b1;
    step();
    in_vld = 1'b0; sel = '0;
    chk("t1_not_early", 64'(out_vld), 64'd0);
    step();
    chk("t1_out_vld", 64'(out_vld), 64'd1);
    chk("t1_dout", 64'(dout), 64'hDEADBEEF);
    chk("t1_idx", 64'(dout_idx), 64'd0);
    chk("t1_hit", 64'(dout_hit), 64'd1);
    step();
    chk("t1_drained", 64'(out_vld), 64'd0);

    // 2: back-to-back, including the remainder group
    for (int i = 0; i < N; i++) din[i*W +: W] = W'(i);
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin in_vld = 1'b1; one_hot(beats2[c]); end
      else begin in_vld = 1'b0; sel = '0; end
      step();
      if (c >= 1 && c <= 3) begin
        chk("t2_vld", 64'(out_vld), 64'd1);
        chk("t2_dout", 64'(dout), 64'(beats2[c-1]));
        chk("t2_idx", 64'(dout_idx), 64'(beats2[c-1]));
      end
      if (c == 4) chk("t2_drained", 64'(out_vld), 64'd0);
    end

    // 3: stall with four beats offered, then release
    acc = 0;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      out_rdy = (c >= 4);
      if (acc < 4) begin in_vld = 1'b1; one_hot(beats3[acc]); end
      else begin in_vld = 1'b0; sel = '0; end
      #1;
      if (c == 2) begin
        chk("t3_in_rdy_low", 64'(in_rdy), 64'd0);
        chk("t3_dout_held_a", 64'(dout), 64'd5);
      end
      if (c == 3) begin
        chk("t3_accepts", 64'(acc), 64'd2);
        chk("t3_out_vld", 64'(out_vld), 64'd1);
        chk("t3_dout_held_b", 64'(dout), 64'd5);
      end
      a_in  = in_vld && in_rdy;
      a_out = out_vld && out_rdy;
      if (a_out) got.push_back(int'(dout));
      step();
      if (a_in) acc++;
    end
    in_vld = 1'b0; sel = '0; out_rdy = 1'b1;
    chk("t3_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_order", (i < got.size()) ? 64'(got[i]) : 64'hFFFF_FFFF, 64'(beats3[i]));
    step(); step();
    chk("t3_drained", 64'(out_vld), 64'd0);

    // 4: zero-hot beat
    sel = '0; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    step();
    chk("t4_vld", 64'(out_vld), 64'd1);
    chk("t4_dout", 64'(dout), 64'd0);
    chk("t4_hit", 64'(dout_hit), 64'd0);
    chk("t4_idx", 64'(dout_idx), 64'd0);
    chk("t4_err", 64'(err_multi), 64'd0);
    step();

    // 5: multi-hot beat
    din[3*W +: W]  = 32'h0F;
    din[40*W +: W] = 32'hF0;
    sel = '0; sel[3] = 1'b1; sel[40] = 1'b1; in_vld = 1'b1;
    step();
    in_vld = 1'b0; sel = '0;
    step();
    chk("t5_vld", 64'(out_vld), 64'd1);
    chk("t5_dout", 64'(dout), 64'hFF);
    chk("t5_idx", 64'(dout_idx), 64'd3);
    chk("t5_hit", 64'(dout_hit), 64'd1);
    chk("t5_err", 64'(err_multi), 64'(ERR_EN));
    step();

    // 6: reset with two beats in flight
    in_vld = 1'b1; one_hot(10);
    step();
    one_hot(11);
    step();
    in_vld = 1'b0; sel = '0;
    chk("t6_pre_vld", 64'(out_vld), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_vld", 64'(out_vld), 64'd0);
    chk("t6_async_dout", 64'(dout), 64'd0);
    step(); step();
    rst = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_vld) hi_cnt++;
    end
    chk("t6_no_ghost", 64'(hi_cnt), 64'd0);
    chk("t6_in_rdy", 64'(in_rdy), 64'd1);
    in_vld = 1'b1; one_hot(77);
    step();
    in_vld = 1'b0; sel = '0;
    step();
    chk("t6_new_vld", 64'(out_vld), 64'd1);
    chk("t6_new_dout", 64'(dout), 64'd77);
    chk("t6_new_idx", 64'(dout_idx), 64'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
